// File: rtl/depth_lut_pkg.sv
// Shared types and arithmetic helpers for the depthwise interpolation LUT scheduler.
package depth_lut_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_FIN,
    S_OUT
  } state_t;

  localparam int ACC_W     = 12;
  localparam int KTAPS     = 9;
  localparam int DRAIN_CYC = 2;
  localparam int DIV_DEN   = 9;
  localparam int DIV_RND   = (DIV_DEN - 1) / 2;

  function automatic int s_clamp_lo(input int bits);
    return -(1 << (bits - 1));
  endfunction

  function automatic int s_clamp_hi(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

  function automatic int u_clamp_hi(input int bits);
    return (1 << bits) - 1;
  endfunction

  function automatic logic signed [ACC_W-1:0] sext8(input logic [7:0] b);
    return {{(ACC_W-8){b[7]}}, b};
  endfunction

  // Rounds half away from zero: work on the magnitude, then restore the sign.
  function automatic logic signed [ACC_W-1:0] round_div9(input logic signed [ACC_W-1:0] x);
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] q;
    mag = x[ACC_W-1] ? -x : x;
    q   = (mag + ACC_W'(DIV_RND)) / ACC_W'(DIV_DEN);
    return x[ACC_W-1] ? -$signed(q) : $signed(q);
  endfunction

  function automatic logic [1:0] tap_row(input logic [3:0] k);
    if (k >= 4'd6) return 2'd2;
    if (k >= 4'd3) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] k);
    case (k)
      4'd1, 4'd4, 4'd7: return 2'd1;
      4'd2, 4'd5, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/depth_lut_postproc.sv
// Round-divide-by-9 and clamp for one sub-pixel phase; packs {msb field, lsb field}.
module depth_lut_postproc
  import depth_lut_pkg::*;
#(
  parameter int MSB_BITS = 6
) (
  input  logic signed [ACC_W-1:0] acc_msb,
  input  logic signed [ACC_W-1:0] acc_lsb,
  output logic        [7:0]       out_byte
);

  localparam int LSB_BITS = 8 - MSB_BITS;
  localparam logic signed [ACC_W-1:0] MSB_LO = ACC_W'(s_clamp_lo(MSB_BITS));
  localparam logic signed [ACC_W-1:0] MSB_HI = ACC_W'(s_clamp_hi(MSB_BITS));
  localparam logic signed [ACC_W-1:0] LSB_LO = '0;
  localparam logic signed [ACC_W-1:0] LSB_HI = ACC_W'(u_clamp_hi(LSB_BITS));

  logic signed [ACC_W-1:0] div_m, div_l, cl_m, cl_l;

  always_comb begin
    div_m = round_div9(acc_msb);
    div_l = round_div9(acc_lsb);
    cl_m  = div_m;
    if (div_m < MSB_LO)      cl_m = MSB_LO;
    else if (div_m > MSB_HI) cl_m = MSB_HI;
    cl_l  = div_l;
    if (div_l < LSB_LO)      cl_l = LSB_LO;
    else if (div_l > LSB_HI) cl_l = LSB_HI;
    out_byte = {MSB_BITS'(cl_m), LSB_BITS'(cl_l)};
  end

endmodule

// File: rtl/depth_lut_sched.sv
// Walks every 3x3 window, drives the MSB/LSB LUT pair per tap, accumulates per phase
// and emits one round/clamped word per window; LUT writes are only accepted while idle.
module depth_lut_sched
  import depth_lut_pkg::*;
#(
  parameter int IMG_H    = 50,
  parameter int IMG_W    = 50,
  parameter int UPSCALE  = 4,
  parameter int MSB_BITS = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic                    cfg_wr_en,
  output logic                    cfg_wr_ready,
  input  logic                    cfg_wr_sel,
  input  logic [9:0]              cfg_wr_addr,
  input  logic [31:0]             cfg_wr_data,
  output logic [1:0]              lut_mode,
  output logic                    lut_wr_sel,
  output logic [9:0]              lut_wr_addr,
  output logic [31:0]             lut_wr_data,
  output logic [3:0]              lut_tap,
  output logic [MSB_BITS-1:0]     lut_msb_idx,
  output logic [7-MSB_BITS:0]     lut_lsb_idx,
  input  logic [8*UPSCALE-1:0]    lut_msb_data,
  input  logic [8*UPSCALE-1:0]    lut_lsb_data,
  output logic                    pix_rd_en,
  output logic [5:0]              pix_rd_row,
  output logic [5:0]              pix_rd_col,
  input  logic [7:0]              pix_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5:0]              out_row,
  output logic [5:0]              out_col,
  output logic [8*UPSCALE-1:0]    out_data
);

  localparam int LSB_BITS = 8 - MSB_BITS;
  localparam int DW       = 8 * UPSCALE;

  state_t                  state, state_nx;
  logic [3:0]              cnt;
  logic [5:0]              row, col;
  logic                    go, wr_acc, hs, last_win;
  logic                    rd_pend, lk_pend, wr_pend;
  logic [3:0]              rd_k;
  logic signed [ACC_W-1:0] acc_msb [UPSCALE];
  logic signed [ACC_W-1:0] acc_lsb [UPSCALE];
  logic [DW-1:0]           fin_data;

  assign wr_acc   = cfg_wr_en & cfg_wr_ready;
  assign go       = (state == S_IDLE) & start & ~cfg_wr_en;
  assign hs       = (state == S_OUT) & out_ready;
  assign last_win = (row == 6'(IMG_H - 3)) && (col == 6'(IMG_W - 3));
  assign busy     = (state != S_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_nx   = state;
    pix_rd_en  = 1'b0;
    pix_rd_row = '0;
    pix_rd_col = '0;
    case (state)
      S_IDLE:  if (go) state_nx = S_FETCH;
      S_FETCH: begin
        pix_rd_en  = 1'b1;
        pix_rd_row = row + {4'b0, tap_row(cnt)};
        pix_rd_col = col + {4'b0, tap_col(cnt)};
        if (cnt == 4'(KTAPS - 1)) state_nx = S_DRAIN;
      end
      S_DRAIN: if (cnt == 4'(DRAIN_CYC - 1)) state_nx = S_FIN;
      S_FIN:   state_nx = S_OUT;
      S_OUT:   if (out_ready) state_nx = last_win ? S_IDLE : S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      row          <= '0;
      col          <= '0;
      done         <= 1'b0;
      cfg_wr_ready <= 1'b0;
    end else begin
      state        <= state_nx;
      if (state_nx != state)                        cnt <= '0;
      else if (state == S_FETCH || state == S_DRAIN) cnt <= cnt + 4'd1;
      if (hs) begin
        if (col == 6'(IMG_W - 3)) begin
          col <= '0;
          row <= (row == 6'(IMG_H - 3)) ? 6'd0 : row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
      done         <= hs & last_win;
      cfg_wr_ready <= (state_nx == S_IDLE);
    end
  end

  // Table writes and tap lookups are three-stage aligned: read (t), lookup (t+1), accumulate (t+2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend     <= 1'b0;
      lut_wr_sel  <= 1'b0;
      lut_wr_addr <= '0;
      lut_wr_data <= '0;
      rd_pend     <= 1'b0;
      rd_k        <= '0;
      lk_pend     <= 1'b0;
    end else begin
      wr_pend <= wr_acc;
      if (wr_acc) begin
        lut_wr_sel  <= cfg_wr_sel;
        lut_wr_addr <= cfg_wr_addr;
        lut_wr_data <= cfg_wr_data;
      end
      rd_pend <= (state == S_FETCH);
      rd_k    <= (state == S_FETCH) ? cnt : 4'd0;
      lk_pend <= rd_pend;
    end
  end

  assign lut_mode    = {wr_pend, rd_pend};
  assign lut_tap     = rd_k;
  assign lut_msb_idx = rd_pend ? pix_rd_data[7:LSB_BITS]   : '0;
  assign lut_lsb_idx = rd_pend ? pix_rd_data[LSB_BITS-1:0] : '0;

  // NOTE: the accumulator arrays are a handful of registers, so they take the async reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < UPSCALE; p++) begin
        acc_msb[p] <= '0;
        acc_lsb[p] <= '0;
      end
    end else if (state == S_FETCH && cnt == 4'd0) begin
      for (int p = 0; p < UPSCALE; p++) begin
        acc_msb[p] <= '0;
        acc_lsb[p] <= '0;
      end
    end else if (lk_pend) begin
      for (int p = 0; p < UPSCALE; p++) begin
        acc_msb[p] <= acc_msb[p] + sext8(lut_msb_data[8*p +: 8]);
        acc_lsb[p] <= acc_lsb[p] + sext8(lut_lsb_data[8*p +: 8]);
      end
    end
  end

  for (genvar p = 0; p < UPSCALE; p++) begin : g_pp
    depth_lut_postproc #(.MSB_BITS(MSB_BITS)) u_pp (
      .acc_msb  (acc_msb[p]),
      .acc_lsb  (acc_lsb[p]),
      .out_byte (fin_data[8*p +: 8])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
    end else if (state == S_FIN) begin
      out_valid <= 1'b1;
      out_data  <= fin_data;
      out_row   <= row;
      out_col   <= col;
    end else if (hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_depth_lut_sched.sv
// Directed sequence with random image/LUT contents against a per-window arithmetic model.
module tb_depth_lut_sched;

  localparam int IMG_H = 50;
  localparam int IMG_W = 50;
  localparam int UP    = 4;
  localparam int MB    = 6;
  localparam int NWIN_C = IMG_W - 2;
  localparam int NWIN   = (IMG_H - 2) * (IMG_W - 2);

  logic clk, rst_n, start, busy, done;
  logic cfg_wr_en, cfg_wr_ready, cfg_wr_sel;
  logic [9:0] cfg_wr_addr;
  logic [31:0] cfg_wr_data;
  logic [1:0] lut_mode;
  logic lut_wr_sel;
  logic [9:0] lut_wr_addr;
  logic [31:0] lut_wr_data;
  logic [3:0] lut_tap;
  logic [MB-1:0] lut_msb_idx;
  logic [7-MB:0] lut_lsb_idx;
  logic [8*UP-1:0] lut_msb_data, lut_lsb_data;
  logic pix_rd_en;
  logic [5:0] pix_rd_row, pix_rd_col;
  logic [7:0] pix_rd_data;
  logic out_valid, out_ready;
  logic [5:0] out_row, out_col;
  logic [8*UP-1:0] out_data;

  depth_lut_sched #(.IMG_H(IMG_H), .IMG_W(IMG_W), .UPSCALE(UP), .MSB_BITS(MB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_sel(cfg_wr_sel),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .lut_mode(lut_mode),
    .lut_wr_sel(lut_wr_sel), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .lut_tap(lut_tap), .lut_msb_idx(lut_msb_idx), .lut_lsb_idx(lut_lsb_idx),
    .lut_msb_data(lut_msb_data), .lut_lsb_data(lut_lsb_data),
    .pix_rd_en(pix_rd_en), .pix_rd_row(pix_rd_row), .pix_rd_col(pix_rd_col),
    .pix_rd_data(pix_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0] img     [IMG_H][IMG_W];
  logic [7:0] tbl_msb [9][UP];
  logic [7:0] tbl_lsb [9][UP];
  logic [7:0] rnd_msb [UP][64];
  logic [7:0] rnd_lsb [UP][4];
  int lut_kind;  // 0: per-tap constant tables, 1: random index-dependent tables

  int hs_cnt = 0, done_cnt = 0, lk_cnt = 0, idx_err = 0, tap_exp = 0;
  logic prev_rd = 1'b0;
  logic [5:0] prev_r = '0, prev_c = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] resp_msb(input int k, input int idx, input int p);
    if (k > 8) return 8'h00;
    if (lut_kind == 0) return tbl_msb[k][p];
    return rnd_msb[p][idx] ^ 8'(k * 37);
  endfunction

  function automatic logic [7:0] resp_lsb(input int k, input int idx, input int p);
    if (k > 8) return 8'h00;
    if (lut_kind == 0) return tbl_lsb[k][p];
    return rnd_lsb[p][idx] ^ 8'(k * 11);
  endfunction

  function automatic int sb(input logic [7:0] b);
    int v;
    v = int'(b);
    return (v > 127) ? v - 256 : v;
  endfunction

  function automatic int rdiv(input int x);
    int a;
    a = (x < 0) ? -x : x;
    return (x < 0) ? -((a + 4) / 9) : (a + 4) / 9;
  endfunction

  // Expected output word for the window whose origin is (r, c).
  function automatic logic [31:0] exp_word(input int r, input int c);
    logic [31:0] w;
    logic [7:0] px;
    int am, al, m, l;
    w = '0;
    for (int p = 0; p < UP; p++) begin
      am = 0;
      al = 0;
      for (int k = 0; k < 9; k++) begin
        px = img[r + k / 3][c + k % 3];
        am += sb(resp_msb(k, int'(px) / 4, p));
        al += sb(resp_lsb(k, int'(px) % 4, p));
      end
      m = rdiv(am);
      if (m < -32) m = -32;
      if (m > 31)  m = 31;
      l = rdiv(al);
      if (l < 0) l = 0;
      if (l > 3) l = 3;
      w[8*p +: 8] = 8'(((m & 63) * 4) + l);
    end
    return w;
  endfunction

  // Frame buffer and LUT pair models, plus a per-lookup index/tap audit.
  always @(posedge clk) begin
    if (pix_rd_en && pix_rd_row < 6'(IMG_H) && pix_rd_col < 6'(IMG_W))
      pix_rd_data <= img[pix_rd_row][pix_rd_col];
    else
      pix_rd_data <= 8'($urandom);
    prev_rd <= pix_rd_en;
    prev_r  <= pix_rd_row;
    prev_c  <= pix_rd_col;
    if (!rst_n) tap_exp <= 0;
    if (lut_mode[0]) begin
      lk_cnt <= lk_cnt + 1;
      for (int p = 0; p < UP; p++) begin
        lut_msb_data[8*p +: 8] <= resp_msb(int'(lut_tap), int'(lut_msb_idx), p);
        lut_lsb_data[8*p +: 8] <= resp_lsb(int'(lut_tap), int'(lut_lsb_idx), p);
      end
      if (!prev_rd || prev_r >= 6'(IMG_H) || prev_c >= 6'(IMG_W))
        idx_err <= idx_err + 1;
      else if (lut_msb_idx != img[prev_r][prev_c][7:2] || lut_lsb_idx != img[prev_r][prev_c][1:0]
               || lut_tap != 4'(tap_exp))
        idx_err <= idx_err + 1;
      tap_exp <= (tap_exp == 8) ? 0 : tap_exp + 1;
    end else begin
      lut_msb_data <= $urandom;
      lut_lsb_data <= $urandom;
    end
  end

  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_oval"},  out_valid, 0);
    check({tag, "_odata"}, out_data, 0);
    check({tag, "_orc"},   {out_row, out_col}, 0);
    check({tag, "_mode"},  lut_mode, 0);
    check({tag, "_rd"},    {pix_rd_en, pix_rd_row, pix_rd_col}, 0);
    check({tag, "_tap"},   {lut_tap, lut_msb_idx, lut_lsb_idx}, 0);
    check({tag, "_wr"},    {lut_wr_sel, lut_wr_addr}, 0);
    check({tag, "_wrd"},   lut_wr_data, 0);
    check({tag, "_rdy"},   cfg_wr_ready, 0);
  endtask

  task automatic get_window(input int r, input int c, input logic [31:0] exp_d, output bit got);
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check("win_valid", got, 1);
    check("win_row",  out_row, 32'(r));
    check("win_col",  out_col, 32'(c));
    check("win_data", out_data, exp_d);
  endtask

  task automatic set_arith();
    int am[4] = '{9, 18, -9, 100};
    int al[4] = '{1, -1, 2, 5};
    for (int k = 0; k < 9; k++)
      for (int p = 0; p < UP; p++) begin
        tbl_msb[k][p] = 8'(am[p]);
        tbl_lsb[k][p] = 8'(al[p]);
      end
  endtask

  task automatic set_round();
    int ar[4] = '{4, 5, -4, -5};
    for (int k = 0; k < 9; k++)
      for (int p = 0; p < UP; p++) begin
        tbl_msb[k][p] = (k == 0) ? 8'(ar[p]) : 8'h00;
        tbl_lsb[k][p] = (k == 0) ? 8'(ar[p]) : 8'h00;
      end
  endtask

  initial begin
    bit got;
    int hs_base, done_base, lk_base;
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_sel = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    lut_kind = 0;
    for (int p = 0; p < UP; p++) begin
      for (int i = 0; i < 64; i++) rnd_msb[p][i] = 8'($urandom);
      for (int i = 0; i < 4; i++)  rnd_lsb[p][i] = 8'($urandom);
    end
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = 8'($urandom);
    set_arith();

    repeat (3) @(negedge clk);
    check_all_zero("rst0");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_rdy", cfg_wr_ready, 1);
    check("idle_busy", busy, 0);

    // LUT load in IDLE
    cfg_wr_en = 1'b1; cfg_wr_sel = 1'b0; cfg_wr_addr = 10'h005; cfg_wr_data = 32'hDEADBEEF;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    check("wr_mode", lut_mode, 2'b10);
    check("wr_sel",  lut_wr_sel, 0);
    check("wr_addr", lut_wr_addr, 10'h005);
    check("wr_data", lut_wr_data, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_mode_off", lut_mode, 2'b00);

    // write and start together: write wins
    cfg_wr_en = 1'b1; cfg_wr_sel = 1'b1; cfg_wr_addr = 10'h02A; cfg_wr_data = 32'hCAFEF00D; start = 1'b1;
    @(negedge clk);
    cfg_wr_en = 1'b0; start = 1'b0;
    check("wrst_mode", lut_mode, 2'b10);
    check("wrst_sel",  lut_wr_sel, 1);
    check("wrst_addr", lut_wr_addr, 10'h02A);
    check("wrst_busy", busy, 0);
    @(negedge clk);
    check("wrst_busy2", {busy, pix_rd_en}, 0);

    // Frame 1: constant per-tap tables on a random image
    hs_base = hs_cnt; done_base = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("f1_busy", busy, 1);
    check("f1_rd0", {pix_rd_en, pix_rd_row, pix_rd_col}, {1'b1, 12'd0});
    cfg_wr_en = 1'b1; cfg_wr_sel = 1'b1; cfg_wr_addr = 10'h3FF; cfg_wr_data = 32'h12345678; start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("busywr_rdy",  cfg_wr_ready, 0);
      check("busywr_mode", lut_mode[1], 0);
    end
    cfg_wr_en = 1'b0; start = 1'b0;
    get_window(0, 0, 32'h7FDE4825, got);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;

    // backpressure on window (0,1)
    get_window(0, 1, 32'h7FDE4825, got);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_data",  out_data, 32'h7FDE4825);
      check("bp_rc",    {out_row, out_col}, {6'd0, 6'd1});
    end
    check("bp_no_hs", hs_cnt - hs_base, 1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_one_hs", hs_cnt - hs_base, 2);
    check("bp_vld_low", out_valid, 0);
    check("bp_next_win", {busy, pix_rd_en}, 2'b11);

    for (int w = 2; w < 100 && got; w++) begin
      get_window(w / NWIN_C, w % NWIN_C, 32'h7FDE4825, got);
      @(posedge clk);
    end

    // abort mid-window 100
    repeat (3) @(negedge clk);
    check("abort_fetching", pix_rd_en, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - done_base, 0);
    check("abort_idle", {busy, out_valid}, 0);

    // Frame 2: rounding window, then random index-dependent tables over a ramp image
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) img[r][c] = 8'(r * IMG_W + c);
    set_round();
    lut_kind = 0;
    hs_base = hs_cnt; done_base = done_cnt; lk_base = lk_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    get_window(0, 0, 32'hFC000500, got);
    lut_kind = 1;
    @(posedge clk);
    for (int w = 1; w < NWIN && got; w++) begin
      get_window(w / NWIN_C, w % NWIN_C, exp_word(w / NWIN_C, w % NWIN_C), got);
      if (w == NWIN - 1) check("last_busy", {busy, done}, 2'b10);
      @(posedge clk);
    end
    @(negedge clk);
    check("done_pulse", {done, busy, cfg_wr_ready}, 3'b101);
    @(negedge clk);
    check("done_clear", done, 0);
    repeat (4) @(negedge clk);
    check("done_count", done_cnt - done_base, 1);
    check("hs_count",   hs_cnt - hs_base, NWIN);
    check("lk_count",   lk_cnt - lk_base, NWIN * 9);
    check("idx_audit",  idx_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/depth_lut_sched.md
Name: depth_lut_sched

Overview:
Time-multiplexed scheduler for the depthwise interpolation LUT pair (6-bit MSB table, 2-bit LSB table). It walks every 3x3 window of an IMG_H x IMG_W frame in raster order and fetches the 9 taps from the frame buffer. Each tap is looked up in both LUTs, and the block accumulates per sub-pixel phase, then applies round-divide-by-9 and clamp. One UPSCALE-byte output word per window goes out on a valid/ready stream. It also gates LUT programming so that table writes can occur only while the datapath is idle.

Parameters:
IMG_H, 50, input frame rows
IMG_W, 50, input frame columns
UPSCALE, 4, sub-pixel phases per window (bytes per LUT word and output word)
MSB_BITS, 6, LUT MSB index width (LSB index = 8-MSB_BITS)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin frame (IDLE only)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last output handshake
cfg_wr_en  in  1  LUT table write request
cfg_wr_ready  out  1  high only in IDLE
cfg_wr_sel  in  1  0=MSB table, 1=LSB table
cfg_wr_addr  in  10  table word address
cfg_wr_data  in  32  table word
lut_mode  out  2  [1]=write enable, [0]=read enable
lut_wr_sel/lut_wr_addr/lut_wr_data  out  1/10/32  registered copies of cfg_wr_*
lut_tap  out  4  tap index 0..8
lut_msb_idx  out  MSB_BITS  pixel[7:8-MSB_BITS]
lut_lsb_idx  out  8-MSB_BITS  pixel[7-MSB_BITS:0]
lut_msb_data, lut_lsb_data  in  8*UPSCALE  returned 1 cycle after lut_mode[0]; byte p = signed phase-p contribution
pix_rd_en  out  1  frame buffer read
pix_rd_row, pix_rd_col  out  6,6  read address; pix_rd_data valid next cycle
pix_rd_data  in  8  pixel
out_valid  out  1  output word valid
out_ready  in  1  consumer ready
out_row, out_col  out  6,6  window origin
out_data  out  8*UPSCALE  byte p = {clampS6(div_msb[p]), clampU2(div_lsb[p])}

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters and accumulators 0. Reset asserted mid-frame aborts the frame without a done pulse.
- States: IDLE -> FETCH (start & !cfg_wr_en) -> DRAIN -> FIN -> OUT -> FETCH (next window) or IDLE (last window, done=1).
- IDLE: cfg_wr_ready=1. cfg_wr_en drives lut_mode=2'b10 next cycle with the registered sel/addr/data. If cfg_wr_en and start arrive together, the write wins and start is dropped. start while busy is ignored.
- FETCH: 9 cycles, tap k=0..8 in order kr=k/3, kc=k%3. pix_rd_en=1, address (row+kr, col+kc). Accumulators are cleared on the first FETCH cycle.
- Pipeline per tap: cycle t pixel read; t+1 lut_mode=2'b01 with lut_tap=k and split idx; t+2 accumulate signed bytes into acc_msb[p] and acc_lsb[p] (12-bit signed, no overflow possible).
- DRAIN: 2 cycles to retire taps 7 and 8.
- FIN: 1 cycle.
  - div = sign(x)*((|x|+4)/9), i.e. round half away from zero.
  - MSB clamp to [-32,31]; LSB clamp to [0,3].
  - out_data/row/col are registered and out_valid=1 entering OUT.
- OUT: out_valid, out_data, out_row and out_col are held stable until out_ready. On the handshake, col increments. At col=IMG_W-3, col wraps to 0 and row increments. At row=IMG_H-3 and col=IMG_W-3, go to IDLE, busy=0, done=1 for one cycle.
- Minimum 13 cycles per window with out_ready=1; (IMG_H-2)*(IMG_W-2) outputs per frame.
- lut_mode is never 2'b11; lut_mode[1] is never set outside IDLE.

Decomposition:
- Package depth_lut_pkg holds:
  - state enum
  - ACC_W=12
  - KTAPS=9
  - clamp bounds
  - round-div-by-9 function
  - rounding-constant localparams
- One sub-module, depth_lut_postproc: combinational div+clamp for one phase, instantiated UPSCALE times.

Test Plan:
- Reset: hold rst_n=0 mid-frame at window 100, release -> all outputs 0, busy=0, no done. Then start -> first out_row/out_col=0/0.
- LUT load: IDLE, cfg_wr_en sel=0 addr=0x005 data=0xDEADBEEF -> lut_mode=2'b10 next cycle with matching addr/data. Same request while busy -> cfg_wr_ready=0, lut_mode[1] stays 0. cfg_wr_en+start together -> write issued, busy stays 0.
- Arithmetic: LUT model returns msb bytes {9,18,-9,100} and lsb bytes {1,-1,2,5} for every tap.
  - acc = 9x each value.
  - expected out bytes: phase0 {9,1}=0x25, phase1 {18,0}=0x48, phase2 {-9,2}=0xDE, phase3 {31,3}=0x7F.
- Rounding: per-tap sums giving acc 4,5,-4,-5 -> div 0,1,0,-1.
- Backpressure: out_ready=0 for 5 cycles -> out_valid=1 and out_data/row/col unchanged. Release -> exactly one handshake, next window starts.
- Full frame: out_ready=1 on a 50x50 ramp image -> 2304 handshakes in raster order, lut_msb_idx/lsb_idx match pixel split per tap, done single pulse, busy falls same cycle.
